// File: rtl/fifo_rd_word_packer_pkg.sv
// Shared types and width helpers for the FIFO read-side word packer.
//   state_t          : packer FSM states (FILL accumulates, HOLD presents a word)
//   clog2_min1()     : ceil(log2(value)), never less than 1
//   lane_width()     : lane index width for a given pack_ratio
//   tmo_width()      : idle counter width able to hold 0..tmo_cycles
package fifo_rd_word_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic int lane_width(input int pack_ratio);
        return clog2_min1(pack_ratio);
    endfunction

    function automatic int tmo_width(input int tmo_cycles);
        return clog2_min1(tmo_cycles + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_word_packer_if.sv
// Bus bundle between the FIFO pop side, the packer and the downstream stream.
//   FIFO side  : empty_d, data_d, clr_in_prog_d (to packer), pop_d_n (from packer)
//   Stream side: out_data, out_be, out_valid (from packer), out_ready (to packer)
// master = the packer, slave = FIFO plus downstream consumer.
interface fifo_rd_word_packer_if #(
    parameter int width      = 8,
    parameter int pack_ratio = 4
);
    logic                        empty_d;
    logic [width-1:0]            data_d;
    logic                        clr_in_prog_d;
    logic                        pop_d_n;
    logic [width*pack_ratio-1:0] out_data;
    logic [pack_ratio-1:0]       out_be;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        input  empty_d, data_d, clr_in_prog_d, out_ready,
        output pop_d_n, out_data, out_be, out_valid
    );

    modport slave (
        output empty_d, data_d, clr_in_prog_d, out_ready,
        input  pop_d_n, out_data, out_be, out_valid
    );
endinterface

// File: rtl/fifo_rd_tmo_cnt.sv
// Saturating idle counter for the packer's partial-word timeout.
//   clk_d, rst_d_n : clock, async active-low reset
//   clr            : synchronous clear (wins over en)
//   en             : count one idle cycle
//   tc             : count has reached tmo_cycles (never set when tmo_cycles==0)
module fifo_rd_tmo_cnt
    import fifo_rd_word_packer_pkg::*;
#(
    parameter int tmo_cycles = 16
) (
    input  logic clk_d,
    input  logic rst_d_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int cnt_w = tmo_width(tmo_cycles);
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(tmo_cycles);

    logic [cnt_w-1:0] cnt;

    always_ff @(posedge clk_d or negedge rst_d_n) begin
        if (!rst_d_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != cnt_max)) begin
            cnt <= cnt + cnt_w'(1);
        end
    end

    assign tc = (tmo_cycles != 0) && (cnt == cnt_max);
endmodule

// File: rtl/fifo_rd_word_packer.sv
// Packs pack_ratio FIFO entries into one wide word on a valid/ready stream.
//   clk_d, rst_d_n : destination clock, async active-low reset
//   init_d_n       : synchronous active-low init (same effect as reset)
//   flush          : emit the partial word (ignored when nothing is accumulated)
//   bus            : FIFO pop side and output stream (fifo_rd_word_packer_if.master)
//   word_cnt       : delivered word counter, only when FIFO_RD_WORD_PACKER_CNT_EN is defined
//
// state | meaning
// FILL  | popping entries into acc lanes; flush/timeout/full word moves to HOLD
// HOLD  | acc presented with out_valid=1 until out_ready
module fifo_rd_word_packer
    import fifo_rd_word_packer_pkg::*;
#(
    parameter int width      = 8,
    parameter int pack_ratio = 4,
    parameter int tmo_cycles = 16
) (
    input  logic clk_d,
    input  logic rst_d_n,
    input  logic init_d_n,
    input  logic flush,
    fifo_rd_word_packer_if.master bus
`ifdef FIFO_RD_WORD_PACKER_CNT_EN
    ,
    output logic [15:0] word_cnt
`endif
);
    localparam int lane_w = lane_width(pack_ratio);
    localparam logic [lane_w-1:0] last_lane = lane_w'(pack_ratio - 1);

    state_t                      state, state_nxt;
    logic                        pop;
    logic                        transfer;
    logic                        lane_last;
    logic                        tmo_tc;
    logic [lane_w-1:0]           lane;
    logic [width*pack_ratio-1:0] acc;
    logic [pack_ratio-1:0]       be;

    assign lane_last = (lane == last_lane);
    assign transfer  = (state == HOLD) && bus.out_ready;

    always_ff @(posedge clk_d or negedge rst_d_n) begin
        if (!rst_d_n) begin
            state <= FILL;
        end else if (!init_d_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (!bus.clr_in_prog_d) begin
                    if (pop && lane_last) begin
                        state_nxt = HOLD;
                    end else if (flush && ((|be) || pop)) begin
                        state_nxt = HOLD;
                    end else if (tmo_tc && !pop) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // a single-lane word is already complete after the refill pop
                    state_nxt = (pop && (pack_ratio == 1)) ? HOLD : FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Pop is also gated by the reset pin so pop_d_n reads 1 the moment reset asserts.
    always_comb begin
        pop = rst_d_n && init_d_n && !bus.empty_d && !bus.clr_in_prog_d
              && ((state == FILL) || bus.out_ready);
        bus.pop_d_n   = !pop;
        bus.out_valid = (state == HOLD);
        bus.out_data  = acc;
        bus.out_be    = be;
    end

    always_ff @(posedge clk_d or negedge rst_d_n) begin
        if (!rst_d_n) begin
            acc  <= '0;
            be   <= '0;
            lane <= '0;
        end else if (!init_d_n) begin
            acc  <= '0;
            be   <= '0;
            lane <= '0;
        end else if (state == FILL) begin
            if (bus.clr_in_prog_d) begin
                acc  <= '0;
                be   <= '0;
                lane <= '0;
            end else if (pop) begin
                acc[int'(lane)*width +: width] <= bus.data_d;
                be[lane]                       <= 1'b1;
                lane                           <= lane_last ? '0 : lane + lane_w'(1);
            end
        end else if (transfer) begin
            acc  <= '0;
            be   <= '0;
            lane <= '0;
            if (pop) begin
                acc[width-1:0] <= bus.data_d;
                be[0]          <= 1'b1;
                lane           <= (pack_ratio == 1) ? '0 : lane_w'(1);
            end
        end
    end

    fifo_rd_tmo_cnt #(
        .tmo_cycles (tmo_cycles)
    ) u_tmo_cnt (
        .clk_d   (clk_d),
        .rst_d_n (rst_d_n),
        .clr     (!init_d_n || pop || bus.clr_in_prog_d || (state != FILL)),
        .en      ((state == FILL) && (|be) && !pop),
        .tc      (tmo_tc)
    );

`ifdef FIFO_RD_WORD_PACKER_CNT_EN
    logic clr_q;

    always_ff @(posedge clk_d or negedge rst_d_n) begin
        if (!rst_d_n) begin
            word_cnt <= '0;
            clr_q    <= 1'b0;
        end else begin
            clr_q <= init_d_n && bus.clr_in_prog_d;
            if (!init_d_n || (bus.clr_in_prog_d && !clr_q)) begin
                word_cnt <= '0;
            end else if (transfer && (word_cnt != 16'hFFFF)) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fifo_rd_word_packer.sv
module tb_fifo_rd_word_packer;
    logic clk_d;
    logic rst_d_n;
    logic init_d_n;
    logic flush;
    int   vecs;
    int   errs;
    int   n;
`ifdef FIFO_RD_WORD_PACKER_CNT_EN
    logic [15:0] word_cnt;
`endif

    fifo_rd_word_packer_if #(.width(8), .pack_ratio(4)) bus ();

    fifo_rd_word_packer #(
        .width      (8),
        .pack_ratio (4),
        .tmo_cycles (16)
    ) dut (
        .clk_d    (clk_d),
        .rst_d_n  (rst_d_n),
        .init_d_n (init_d_n),
        .flush    (flush),
        .bus      (bus.master)
`ifdef FIFO_RD_WORD_PACKER_CNT_EN
        ,
        .word_cnt (word_cnt)
`endif
    );

    initial clk_d = 1'b0;
    always #5 clk_d = ~clk_d;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        bus.data_d  = b;
        bus.empty_d = 1'b0;
        #1;
        chk("pop_low", {31'd0, bus.pop_d_n}, 32'd0);
        @(posedge clk_d);
        #1;
    endtask

    initial begin
        vecs              = 0;
        errs              = 0;
        rst_d_n           = 1'b0;
        init_d_n          = 1'b1;
        flush             = 1'b0;
        bus.empty_d       = 1'b0;
        bus.data_d        = 8'h5A;
        bus.clr_in_prog_d = 1'b0;
        bus.out_ready     = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_pop_n", {31'd0, bus.pop_d_n}, 32'd1);
        chk("rst_data", bus.out_data, 32'h0);
        chk("rst_be", {28'd0, bus.out_be}, 32'h0);
        bus.empty_d = 1'b1;
        rst_d_n     = 1'b1;
        tick();

        // full word, back-to-back
        feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
        bus.empty_d = 1'b1;
        chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("full_data", bus.out_data, 32'h44332211);
        chk("full_be", {28'd0, bus.out_be}, 32'hF);
        tick();
        chk("full_pulse", {31'd0, bus.out_valid}, 32'd0);

        // backpressure
        bus.out_ready = 1'b0;
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        bus.data_d = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("bp_pop_n", {31'd0, bus.pop_d_n}, 32'd1);
            chk("bp_data", bus.out_data, 32'h04030201);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_refill_pop", {31'd0, bus.pop_d_n}, 32'd0);
        tick();
        bus.empty_d = 1'b1;
        chk("bp_after_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_lane0_data", bus.out_data, 32'h00000055);
        chk("bp_lane0_be", {28'd0, bus.out_be}, 32'h1);
        feed(8'h66); feed(8'h77); feed(8'h88);
        bus.empty_d = 1'b1;
        chk("bp_word2", bus.out_data, 32'h88776655);
        tick();
        chk("bp_word2_done", {31'd0, bus.out_valid}, 32'd0);

        // idle timeout
        bus.out_ready = 1'b0;
        feed(8'hAA); feed(8'hBB);
        bus.empty_d = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, 32'd17);
        chk("tmo_data", bus.out_data, 32'h0000BBAA);
        chk("tmo_be", {28'd0, bus.out_be}, 32'h3);
        bus.out_ready = 1'b1;
        tick();
        chk("tmo_done", {31'd0, bus.out_valid}, 32'd0);

        // flush with same-cycle pop, then flush on empty accumulator
        feed(8'h01); feed(8'h02);
        bus.data_d  = 8'h03;
        bus.empty_d = 1'b0;
        flush       = 1'b1;
        #1;
        chk("flush_pop", {31'd0, bus.pop_d_n}, 32'd0);
        tick();
        flush       = 1'b0;
        bus.empty_d = 1'b1;
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("flush_be", {28'd0, bus.out_be}, 32'h7);
        chk("flush_data", bus.out_data, 32'h00030201);
        tick();
        chk("flush_done", {31'd0, bus.out_valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_empty_1", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("flush_empty_2", {31'd0, bus.out_valid}, 32'd0);
`ifdef FIFO_RD_WORD_PACKER_CNT_EN
        chk("word_cnt_5", {16'd0, word_cnt}, 32'd5);
`endif

        // clear in progress
        feed(8'h10); feed(8'h20);
        bus.clr_in_prog_d = 1'b1;
        bus.empty_d       = 1'b0;
        bus.data_d        = 8'h99;
        #1;
        chk("clr_no_pop", {31'd0, bus.pop_d_n}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clr_no_pop", {31'd0, bus.pop_d_n}, 32'd1);
        end
        bus.clr_in_prog_d = 1'b0;
        bus.out_ready     = 1'b0;
        feed(8'h31); feed(8'h32); feed(8'h33); feed(8'h34);
        bus.empty_d = 1'b1;
        chk("clr_clean_data", bus.out_data, 32'h34333231);
        chk("clr_clean_be", {28'd0, bus.out_be}, 32'hF);
        bus.clr_in_prog_d = 1'b1;
        bus.empty_d       = 1'b0;
        #1;
        chk("clr_hold_pop", {31'd0, bus.pop_d_n}, 32'd1);
        tick();
        chk("clr_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("clr_hold_data", bus.out_data, 32'h34333231);
        bus.out_ready = 1'b1;
        tick();
        bus.clr_in_prog_d = 1'b0;
        bus.empty_d       = 1'b1;
        chk("clr_hold_done", {31'd0, bus.out_valid}, 32'd0);
        chk("clr_next_empty", {28'd0, bus.out_be}, 32'h0);
`ifdef FIFO_RD_WORD_PACKER_CNT_EN
        chk("word_cnt_clr", {16'd0, word_cnt}, 32'd1);
`endif

        // async reset mid-word
        feed(8'hA1);
        bus.data_d = 8'hA2;
        rst_d_n    = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_pop_n", {31'd0, bus.pop_d_n}, 32'd1);
        chk("rst_mid_be", {28'd0, bus.out_be}, 32'h0);
`ifdef FIFO_RD_WORD_PACKER_CNT_EN
        chk("word_cnt_rst", {16'd0, word_cnt}, 32'd0);
`endif
        bus.empty_d = 1'b1;
        tick();
        rst_d_n = 1'b1;
        tick();

        // async reset while holding
        bus.out_ready = 1'b0;
        feed(8'hB1); feed(8'hB2); feed(8'hB3); feed(8'hB4);
        bus.data_d = 8'hC0;
        chk("rst_hold_pre", {31'd0, bus.out_valid}, 32'd1);
        rst_d_n = 1'b0;
        #1;
        chk("rst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_hold_pop_n", {31'd0, bus.pop_d_n}, 32'd1);
        chk("rst_hold_data", bus.out_data, 32'h0);
        bus.empty_d = 1'b1;
        tick();
        rst_d_n = 1'b1;
        tick();

        // synchronous init while holding
        feed(8'hD1); feed(8'hD2); feed(8'hD3); feed(8'hD4);
        bus.empty_d = 1'b0;
        chk("init_pre", {31'd0, bus.out_valid}, 32'd1);
        init_d_n = 1'b0;
        #1;
        chk("init_pop_n", {31'd0, bus.pop_d_n}, 32'd1);
        chk("init_sync_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        chk("init_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("init_be", {28'd0, bus.out_be}, 32'h0);
        chk("init_data", bus.out_data, 32'h0);
        init_d_n    = 1'b1;
        bus.empty_d = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fifo_rd_word_packer.md
Name: fifo_rd_word_packer

Overview:
Destination-domain consumer for the dual-clock prefetch FIFO controller. Pops width-bit entries from the FIFO's pop-side interface (data_d valid whenever empty_d=0) and packs pack_ratio entries into one wide word. Presents the word on a valid/ready stream with per-lane byte enables. Flushes partial words on request or after an idle timeout. Honours the FIFO's clear-in-progress indication.

Parameters:
width, 8, FIFO entry width in bits (1..256)
pack_ratio, 4, entries per output word (1..16)
tmo_cycles, 16, idle cycles before a partial word is emitted; 0 disables timeout (0..65535)

Ports:
clk_d  input  1  destination-domain clock
rst_d_n  input  1  asynchronous active-low reset
init_d_n  input  1  synchronous active-low init; same effect as reset, on clock edge
empty_d  input  1  FIFO empty; data_d valid when 0
data_d  input  width  FIFO head entry
clr_in_prog_d  input  1  FIFO clear in progress
pop_d_n  output  1  active-low pop to FIFO (combinational)
flush  input  1  force emission of partial word
out_data  output  width*pack_ratio  packed word; lane 0 in LSBs
out_be  output  pack_ratio  lane valid mask; bit i covers lane i
out_valid  output  1  word available
out_ready  input  1  downstream accepts word

Behaviour:
- Reset or init_d_n=0: state FILL, lane=0, tmo_cnt=0, acc=0, out_valid=0, out_data=0, out_be=0, pop_d_n=1.
- Internal registers: state {FILL, HOLD}; lane index (width clog2(pack_ratio), min 1); acc; be; tmo_cnt.
- pop = ~empty_d & ~clr_in_prog_d & init_d_n & (state==FILL | out_ready). pop_d_n = ~pop.
- The out_ready -> pop_d_n combinational path is intentional.
- FILL behaviour:
  - Pop: acc lane[lane] <= data_d, be[lane] <= 1, lane++, tmo_cnt <= 0.
  - Pop when lane==pack_ratio-1: -> HOLD, out_valid=1 next cycle, out_be all ones, lane <= 0.
- Flush in FILL:
  - flush=1 with be!=0 (or with a pop this cycle): -> HOLD after including any same-cycle byte; out_be = accumulated mask.
  - flush with be==0 and no pop: ignored.
- Timeout in FILL:
  - tmo_cnt increments each cycle with be!=0 and no pop.
  - When tmo_cnt reaches tmo_cycles: -> HOLD; out_valid rises tmo_cycles+1 cycles after the last pop.
  - tmo_cnt saturates and clears on pop or on leaving FILL.
- HOLD behaviour:
  - out_data/out_be stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready: transfer; acc, be and lane are cleared.
  - A same-cycle pop lands in lane 0 of the new word. State becomes FILL, or stays HOLD if pack_ratio==1.
- clr_in_prog_d=1:
  - No pops.
  - In FILL: acc, be, lane and tmo_cnt are cleared (partial data discarded).
  - In HOLD: the held word is still delivered; the next word is empty.
- Unused high lanes of out_data in partial words are 0.
- Reset mid-word: all data is lost and outputs go to reset values immediately (asynchronous).

Optional Feature:
FIFO_RD_WORD_PACKER_CNT_EN
- Defined: adds output word_cnt (16 bits). It increments on each out_valid & out_ready and saturates at 16'hFFFF. It is cleared by reset, by init_d_n=0 and by clr_in_prog_d rising.
- Undefined: the port and counter are absent. Core behaviour is identical in both builds.

Decomposition:
- Package fifo_rd_word_packer_pkg holds:
  - state enum {FILL, HOLD};
  - localparam functions for lane and timeout-counter widths (clog2 with minimum 1).
- One sub-module, fifo_rd_tmo_cnt: saturating idle counter with clear, enable and a terminal-count flag.
- Packing, handshake and FSM stay in the top module.

Test Plan:
- Full word: width=8, pack_ratio=4. Feed 0x11,0x22,0x33,0x44 back-to-back with out_ready=1 -> out_data=0x44332211, out_be=4'b1111, one out_valid pulse, 4 pop_d_n low cycles.
- Backpressure: out_ready=0 for 5 cycles after a word completes, FIFO non-empty -> pop_d_n stays 1, out_data stable. When out_ready=1, the same-cycle pop places the next byte in lane 0.
- Timeout: tmo_cycles=16. Pop 0xAA,0xBB, then empty_d=1 -> out_valid rises 17 cycles after the last pop with out_data=0x0000BBAA, out_be=4'b0011.
- Flush: flush=1 in the same cycle as the third pop (0x01,0x02,0x03) -> next cycle out_be=4'b0111, out_data=0x00030201. Flush with an empty accumulator produces no word.
- Clear: clr_in_prog_d=1 after 2 bytes -> no pops during clear and the partial bytes are dropped. The next 4 bytes form a clean full word. A word held in HOLD during clear is still delivered.
- Reset/init: assert rst_d_n=0 mid-word and while in HOLD -> out_valid=0, pop_d_n=1 immediately. init_d_n=0 gives the same result at the next edge. With FIFO_RD_WORD_PACKER_CNT_EN defined, word_cnt returns to 0.
